// File: rtl/rotary_filter_pkg.sv
// Shared constants for the rotary encoder front end: decode state encoding,
// default debounce sizing and channel indices.
package rotary_filter_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_IDLE  = 2'd0;
    localparam fsm_state_t S_LEFT  = 2'd1;
    localparam fsm_state_t S_RIGHT = 2'd2;
    localparam fsm_state_t S_WAIT  = 2'd3;

    localparam int STABLE_CYCLES_DEF = 6;
    localparam int CNT_W_DEF         = 4;

    localparam int CH_A = 0;
    localparam int CH_B = 1;

endpackage

// File: rtl/rotary_debounce.sv
// One encoder channel: two-flop synchroniser followed by a stability counter
// that only lets the clean level follow after STABLE_CYCLES agreeing samples.
module rotary_debounce
    import rotary_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic clean
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            clean  <= 1'b0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
            // any sample agreeing with clean restarts the count, rejecting the glitch
            if (sync_2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotary_filter.sv
// Rotary encoder front end: debounced channels, quadrature detent decode into
// one-cycle left/right pulses; ROTARY_FILTER_COUNT_EN adds a signed position count.
//
// state   | meaning
// S_IDLE  | both channels low, waiting for the first edge of a detent
// S_LEFT  | channel A led, left detent in progress
// S_RIGHT | channel B led, right detent in progress
// S_WAIT  | detent done or ambiguous, waiting for both channels low
module rotary_filter
    import rotary_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        rotary,
    output logic [1:0]        rotary_clean,
    output logic              rotary_left,
    output logic              rotary_right
`ifdef ROTARY_FILTER_COUNT_EN
    ,
    output logic signed [7:0] rotary_position
`endif
);

    fsm_state_t state;
    fsm_state_t state_nxt;
    logic       left_nxt;
    logic       right_nxt;

    rotary_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_debounce_a (
        .clock (clock),
        .reset (reset),
        .pin   (rotary[CH_A]),
        .clean (rotary_clean[CH_A])
    );

    rotary_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_debounce_b (
        .clock (clock),
        .reset (reset),
        .pin   (rotary[CH_B]),
        .clean (rotary_clean[CH_B])
    );

    always_comb begin
        state_nxt = state;
        left_nxt  = 1'b0;
        right_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                case (rotary_clean)
                    2'b01:   state_nxt = S_LEFT;
                    2'b10:   state_nxt = S_RIGHT;
                    2'b11:   state_nxt = S_WAIT;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_LEFT: begin
                case (rotary_clean)
                    2'b11: begin
                        state_nxt = S_WAIT;
                        left_nxt  = 1'b1;
                    end
                    2'b00:   state_nxt = S_IDLE;
                    2'b10:   state_nxt = S_RIGHT;
                    default: state_nxt = S_LEFT;
                endcase
            end
            S_RIGHT: begin
                case (rotary_clean)
                    2'b11: begin
                        state_nxt = S_WAIT;
                        right_nxt = 1'b1;
                    end
                    2'b00:   state_nxt = S_IDLE;
                    2'b01:   state_nxt = S_LEFT;
                    default: state_nxt = S_RIGHT;
                endcase
            end
            default: begin
                if (rotary_clean == 2'b00) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rotary_left  <= 1'b0;
            rotary_right <= 1'b0;
        end else begin
            state        <= state_nxt;
            rotary_left  <= left_nxt;
            rotary_right <= right_nxt;
        end
    end

`ifdef ROTARY_FILTER_COUNT_EN
    // updated on the same edge that raises the pulse, so both are visible together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rotary_position <= '0;
        end else if (right_nxt) begin
            rotary_position <= rotary_position + 8'sd1;
        end else if (left_nxt) begin
            rotary_position <= rotary_position - 8'sd1;
        end
    end
`endif

endmodule

// File: tb/tb_rotary_filter.sv
// Self-checking bench for rotary_filter: directed detent scenarios plus random
// pin activity, compared every cycle against a window-based behavioural model.
module tb_rotary_filter;

    localparam int S = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rotary = 2'b00;
    logic [1:0] rotary_clean;
    logic       rotary_left;
    logic       rotary_right;
`ifdef ROTARY_FILTER_COUNT_EN
    logic [7:0] rotary_position;
`endif

    always #5 clock = ~clock;

    rotary_filter #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .rotary       (rotary),
        .rotary_clean (rotary_clean),
        .rotary_left  (rotary_left),
        .rotary_right (rotary_right)
`ifdef ROTARY_FILTER_COUNT_EN
        ,
        .rotary_position (rotary_position)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
        end
    endtask

    // Reference model: pin history, clean levels, detent tracker
    logic [1:0] hist [32];
    logic [1:0] m_clean;
    int         m_mode;      // 0 idle, 1 A led, 2 B led, 3 waiting for 00
    logic       m_left;
    logic       m_right;
    logic [7:0] m_pos;

    int cyc = 0;
    int n_left = 0;
    int n_right = 0;
    int last_left_cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) hist[i] = 2'b00;
        m_clean = 2'b00;
        m_mode  = 0;
        m_left  = 1'b0;
        m_right = 1'b0;
        m_pos   = 8'h00;
    endtask

    task automatic model_step(input logic [1:0] pins);
        int ev;
        logic [1:0] nc;
        for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pins;
        ev = 0;
        case (m_mode)
            0: if (m_clean == 2'b01) m_mode = 1;
               else if (m_clean == 2'b10) m_mode = 2;
               else if (m_clean == 2'b11) m_mode = 3;
            1: if (m_clean == 2'b11) begin m_mode = 3; ev = -1; end
               else if (m_clean == 2'b00) m_mode = 0;
               else if (m_clean == 2'b10) m_mode = 2;
            2: if (m_clean == 2'b11) begin m_mode = 3; ev = 1; end
               else if (m_clean == 2'b00) m_mode = 0;
               else if (m_clean == 2'b01) m_mode = 1;
            default: if (m_clean == 2'b00) m_mode = 0;
        endcase
        // clean follows once the last S synchronised samples (pin delayed 2) all disagree
        nc = m_clean;
        for (int ch = 0; ch < 2; ch++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int i = 0; i < S; i++)
                if (hist[2+i][ch] == m_clean[ch]) all_diff = 1'b0;
            if (all_diff) nc[ch] = ~m_clean[ch];
        end
        m_clean = nc;
        m_left  = (ev == -1);
        m_right = (ev == 1);
        m_pos   = m_pos + 8'(ev);
    endtask

    task automatic tick(input logic [1:0] pins);
        rotary = pins;
        @(posedge clock);
        cyc++;
        model_step(pins);
        @(negedge clock);
        check_val("clean", 32'(rotary_clean), 32'(m_clean));
        check_val("left", 32'(rotary_left), 32'(m_left));
        check_val("right", 32'(rotary_right), 32'(m_right));
        check_val("exclusive", 32'(rotary_left & rotary_right), 32'd0);
`ifdef ROTARY_FILTER_COUNT_EN
        check_val("position", 32'(rotary_position), 32'(m_pos));
`endif
        if (rotary_left) begin
            n_left++;
            last_left_cyc = cyc;
        end
        if (rotary_right) n_right++;
    endtask

    task automatic hold(input logic [1:0] pins, input int n);
        for (int i = 0; i < n; i++) tick(pins);
    endtask

    task automatic detent(input bit right, input int h);
        hold(right ? 2'b10 : 2'b01, h);
        hold(2'b11, h);
        hold(2'b00, h);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_clean", 32'(rotary_clean), 32'd0);
        check_val("rst_pulses", 32'({rotary_left, rotary_right}), 32'd0);
        for (int i = 0; i < n; i++) begin
            rotary = 2'($urandom);
            @(posedge clock);
            @(negedge clock);
            check_val("rst_clean", 32'(rotary_clean), 32'd0);
            check_val("rst_pulses", 32'({rotary_left, rotary_right}), 32'd0);
`ifdef ROTARY_FILTER_COUNT_EN
            check_val("rst_position", 32'(rotary_position), 32'd0);
`endif
        end
        rotary = 2'b00;
        reset  = 1'b1;
    endtask

    initial begin
        int c0;
        bit clean_a_moved;
        model_reset();
        @(negedge clock);

        // reset with pins toggling, then quiet release
        do_reset(8);
        n_left = 0; n_right = 0;
        hold(2'b00, 20);
        check_val("idle_left", 32'(n_left), 32'd0);
        check_val("idle_right", 32'(n_right), 32'd0);

        // clean left turn and its pin-to-pulse latency
        hold(2'b01, 30);
        c0 = cyc;
        hold(2'b11, 30);
        hold(2'b00, 30);
        check_val("left_count", 32'(n_left), 32'd1);
        check_val("left_no_right", 32'(n_right), 32'd0);
        check_val("left_latency", 32'(last_left_cyc - c0), 32'(3 + S));
`ifdef ROTARY_FILTER_COUNT_EN
        check_val("left_position", 32'(rotary_position), 32'hFF);
`endif

        // clean right turn
        n_left = 0; n_right = 0;
        detent(1'b1, 30);
        check_val("right_count", 32'(n_right), 32'd1);
        check_val("right_no_left", 32'(n_left), 32'd0);
`ifdef ROTARY_FILTER_COUNT_EN
        check_val("right_position", 32'(rotary_position), 32'h00);
`endif

        // bounce rejection on channel A
        n_left = 0; n_right = 0;
        clean_a_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick((i < 4 || (i >= 6 && i < 10)) ? 2'b01 : 2'b00);
            if (rotary_clean[0]) clean_a_moved = 1'b1;
        end
        check_val("bounce_clean_a", 32'(clean_a_moved), 32'd0);
        detent(1'b0, 30);
        check_val("bounce_left", 32'(n_left), 32'd1);
        check_val("bounce_right", 32'(n_right), 32'd0);

        // aborted detent, then a right detent still decodes from idle
        n_left = 0; n_right = 0;
        hold(2'b01, 30);
        hold(2'b00, 30);
        check_val("abort_pulses", 32'(n_left + n_right), 32'd0);
        detent(1'b1, 30);
        check_val("abort_then_right", 32'(n_right), 32'd1);

        // both channels together is ambiguous; wait state ignores single-channel moves
        n_left = 0; n_right = 0;
        hold(2'b11, 30);
        hold(2'b01, 30);
        hold(2'b11, 30);
        hold(2'b10, 30);
        hold(2'b11, 30);
        hold(2'b00, 30);
        check_val("simul_pulses", 32'(n_left + n_right), 32'd0);

        // reset mid-detent discards the partial sequence
        hold(2'b01, 30);
        do_reset(5);
        n_left = 0; n_right = 0;
        hold(2'b00, 30);
        check_val("midrst_none", 32'(n_left + n_right), 32'd0);
        detent(1'b0, 30);
        check_val("midrst_left", 32'(n_left), 32'd1);

`ifdef ROTARY_FILTER_COUNT_EN
        // position wrap
        do_reset(3);
        hold(2'b00, 10);
        for (int i = 0; i < 128; i++) detent(1'b1, 10);
        check_val("wrap_pos_max", 32'(rotary_position), 32'h80);
        detent(1'b0, 10);
        check_val("wrap_neg_min", 32'(rotary_position), 32'h7F);
`endif

        // random pin activity, checked cycle by cycle against the model
        for (int seg = 0; seg < 300; seg++) begin
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
            if ($urandom_range(0, 40) == 0) do_reset(int'($urandom_range(1, 4)));
        end
        hold(2'b00, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rotary_filter.md
Name: rotary_filter

Overview:
- Front-end stage between the raw two-pin rotary encoder pins and the Rotary instruction peripheral.
- Synchronises and debounces both encoder channels.
- Decodes the quadrature sequence into one-cycle left/right turn pulses; the Rotary peripheral latches these as sticky status bits.
- Also exports the clean channel levels for diagnostics.

Parameters:
- STABLE_CYCLES, 6: consecutive cycles a synchronised channel must hold a new level before the clean level follows; legal range 1..(2**CNT_W - 1).
- CNT_W, 4: width of each debounce counter.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; block is in reset while 0.
- rotary  input  2  raw encoder pins, asynchronous; bit 0 = channel A, bit 1 = channel B.
- rotary_clean  output  2  debounced channel levels.
- rotary_left  output  1  one-cycle pulse per completed left detent.
- rotary_right  output  1  one-cycle pulse per completed right detent.
- rotary_position  output  8  signed detent count; present only with ROTARY_FILTER_COUNT_EN.

Behaviour:
- Reset (reset=0, asynchronous): synchronisers=00, counters=0, rotary_clean=00, FSM=S_IDLE, rotary_left=0, rotary_right=0, rotary_position=0. Release is synchronous to the next rising edge.
- Synchroniser: two flops per channel; sync = rotary delayed by 2 cycles.
- Debounce, per channel independently:
  - If sync == clean, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches STABLE_CYCLES-1 and sync still differs, clean takes sync on that edge and the counter clears.
  - Any return of sync to clean before then clears the counter, so the glitch is fully rejected.
  - Pin-to-clean latency = 2 + STABLE_CYCLES cycles.
- Decode FSM operates on rotary_clean, one transition per cycle:
  - S_IDLE: 01 -> S_LEFT; 10 -> S_RIGHT; 11 -> S_WAIT (ambiguous, no event); 00 -> stay.
  - S_LEFT: 11 -> S_WAIT and assert rotary_left next cycle; 00 -> S_IDLE (aborted, no event); 10 -> S_RIGHT; 01 -> stay.
  - S_RIGHT: mirror of S_LEFT; 11 -> S_WAIT and assert rotary_right.
  - S_WAIT: 00 -> S_IDLE; any other value -> stay. No further events until both channels return low.
- Pulses are registered and high exactly one cycle per detent.
- rotary_left and rotary_right are never high in the same cycle.
- Clean-to-pulse latency = 1 cycle; total pin-to-pulse = 3 + STABLE_CYCLES cycles.
- Both channels changing in the same clean update (00->11 or 11->00) is treated as ambiguous: 00->11 goes to S_WAIT with no pulse.
- Reset mid-detent discards the partial sequence and any pending pulse.

Optional Feature:
- Macro: ROTARY_FILTER_COUNT_EN.
- Defined:
  - Adds the rotary_position port and an 8-bit register.
  - +1 on each rotary_right pulse, -1 on each rotary_left pulse, in the same cycle the pulse is high.
  - Two's-complement wrap: 127+1 = -128, -128-1 = 127.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package rotary_filter_pkg:
  - FSM state encoding: S_IDLE=2'd0, S_LEFT=2'd1, S_RIGHT=2'd2, S_WAIT=2'd3.
  - Default STABLE_CYCLES and CNT_W constants.
  - Channel index constants: CH_A=0, CH_B=1.
- Sub-module rotary_debounce: one channel, comprising the 2-flop synchroniser, counter and clean flop; parameterised by STABLE_CYCLES and CNT_W; instantiated twice.
- Decode FSM and optional counter live in rotary_filter.

Test Plan:
- Reset: hold reset=0 with rotary toggling -> all outputs 0 and rotary_clean=00; release -> outputs stay 0 while rotary=00.
- Clean left turn (rotary 00->01, hold 30 cycles, ->11, hold 30, ->00) -> exactly one rotary_left pulse, 9 cycles after the 01->11 pin change; rotary_right stays 0; rotary_position=-1 (with macro).
- Clean right turn (00->10->11->00, 30-cycle holds) -> one rotary_right pulse; rotary_position returns to 0 after the previous left turn.
- Bounce rejection: pulse channel A high for 4 cycles, low 2, high 4, then stable sequence to 11 and 00 -> rotary_clean[0] never changes during the 4-cycle glitches; exactly one rotary_left pulse.
- Aborted detent: 00->01 (stable 30 cycles) ->00 -> no pulse, FSM back to S_IDLE. Direct 00->11 with both pins switching the same cycle -> no pulse, S_WAIT until 00.
- Wrap (macro on): 128 consecutive right detents from 0 -> rotary_position=-128 (8'h80); one left detent -> 127 (8'h7F).
- Reset mid-detent: assert reset while in S_LEFT -> no pulse after release; the next full left detent yields one pulse.
